// File: rtl/sprite_palette_arbiter_if.sv
// Handshake bundle between the sprite layers, the shared palette lookup and the compositor.
interface sprite_palette_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 10
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*IDX_W-1:0] req_index;
    logic [NUM_REQ*TAG_W-1:0] req_tag;

    logic [IDX_W-1:0]         pal_index;
    logic [3:0]               pal_red;
    logic [3:0]               pal_green;
    logic [3:0]               pal_blue;

    logic                     out_valid;
    logic                     out_ready;
    logic [3:0]               out_red;
    logic [3:0]               out_green;
    logic [3:0]               out_blue;
    logic [SRC_W-1:0]         out_src;
    logic [TAG_W-1:0]         out_tag;
    logic                     out_transparent;

    modport slave (
        input  req_valid, req_index, req_tag, pal_red, pal_green, pal_blue, out_ready,
        output req_ready, pal_index, out_valid, out_red, out_green, out_blue,
               out_src, out_tag, out_transparent
    );

    modport master (
        output req_valid, req_index, req_tag, pal_red, pal_green, pal_blue, out_ready,
        input  req_ready, pal_index, out_valid, out_red, out_green, out_blue,
               out_src, out_tag, out_transparent
    );
endinterface

// File: rtl/sprite_palette_arbiter.sv
// Round-robin arbiter sharing one palette lookup among sprite layers; registered colour out.
// Optional feature macro: PAL_FLASH_EN (blinks requester 0 white every 4 frames).
module sprite_palette_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int IDX_W           = 4,
    parameter int TAG_W           = 10,
    parameter int TRANSPARENT_IDX = 0
) (
    input logic clk,
    input logic reset_n,
`ifdef PAL_FLASH_EN
    input logic flash_en,
    input logic frame_start,
`endif
    sprite_palette_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic [SRC_W-1:0] rr_ptr_q;
    logic             out_valid_q;
    logic [11:0]      colour_q;
    logic [SRC_W-1:0] src_q;
    logic [TAG_W-1:0] tag_q;
    logic             transp_q;

    logic             can_accept;
    logic             found;
    logic             do_grant;
    logic [SRC_W-1:0] grant_id;
    logic [IDX_W-1:0] grant_index;
    logic [TAG_W-1:0] grant_tag;
    logic             transp_d;
    logic [11:0]      colour_d;
    int unsigned      cand;

`ifdef PAL_FLASH_EN
    logic [2:0] flash_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flash_cnt_q <= 3'd0;
        end else if (!flash_en) begin
            flash_cnt_q <= 3'd0;
        end else if (frame_start) begin
            flash_cnt_q <= flash_cnt_q + 3'd1;
        end
    end
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        can_accept = !out_valid_q || bus.out_ready;
        found      = 1'b0;
        grant_id   = '0;
        cand       = 0;
        // Search starts just after the last winner, so the last winner has lowest priority.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && bus.req_valid[cand]) begin
                found    = 1'b1;
                grant_id = SRC_W'(cand);
            end
        end
        do_grant    = reset_n && can_accept && found;
        grant_index = bus.req_index[grant_id*IDX_W +: IDX_W];
        grant_tag   = bus.req_tag[grant_id*TAG_W +: TAG_W];
        transp_d    = (grant_index == IDX_W'(TRANSPARENT_IDX));
        colour_d    = {bus.pal_red, bus.pal_green, bus.pal_blue};
`ifdef PAL_FLASH_EN
        if (grant_id == '0 && flash_en && flash_cnt_q[2] && !transp_d) begin
            colour_d = 12'hFFF;
        end
`endif
    end

    assign bus.req_ready = do_grant ? (NUM_REQ'(1) << grant_id) : '0;
    assign bus.pal_index = do_grant ? grant_index : '0;

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            colour_q    <= 12'h000;
            src_q       <= '0;
            tag_q       <= '0;
            transp_q    <= 1'b0;
            rr_ptr_q    <= SRC_W'(NUM_REQ - 1);
        end else if (do_grant) begin
            out_valid_q <= 1'b1;
            colour_q    <= colour_d;
            src_q       <= grant_id;
            tag_q       <= grant_tag;
            transp_q    <= transp_d;
            rr_ptr_q    <= grant_id;
        end else if (can_accept) begin
            // Output drained with nobody asking: data fields keep their last values.
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid       = out_valid_q;
    assign bus.out_red         = colour_q[11:8];
    assign bus.out_green       = colour_q[7:4];
    assign bus.out_blue        = colour_q[3:0];
    assign bus.out_src         = src_q;
    assign bus.out_tag         = tag_q;
    assign bus.out_transparent = transp_q;
endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// Directed bench for sprite_palette_arbiter with a per-cycle reference model and literal pins.
module tb_sprite_palette_arbiter;
    localparam int N = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic flash_en;
    logic frame_start;
    int   n_vec = 0;
    int   n_err = 0;

    sprite_palette_arbiter_if #(.NUM_REQ(N), .IDX_W(4), .TAG_W(10)) bus ();

    sprite_palette_arbiter #(.NUM_REQ(N), .IDX_W(4), .TAG_W(10), .TRANSPARENT_IDX(0)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
`ifdef PAL_FLASH_EN
        .flash_en    (flash_en),
        .frame_start (frame_start),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pal_rgb(input logic [3:0] i);
        case (i)
            4'd0:    pal_rgb = 12'hF0C;
            4'd1:    pal_rgb = 12'h123;
            4'd2:    pal_rgb = 12'h456;
            4'd3:    pal_rgb = 12'h0AF;
            default: pal_rgb = {i, ~i, i ^ 4'h5};
        endcase
    endfunction

    always_comb {bus.pal_red, bus.pal_green, bus.pal_blue} = pal_rgb(bus.pal_index);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the output register must hold after the next rising edge.
    int          m_last;
    logic        m_valid;
    logic [11:0] m_rgb;
    int          m_src;
    logic [9:0]  m_tag;
    logic        m_transp;
    int          m_flash;

    task automatic model_reset();
        m_last = N - 1; m_valid = 0; m_rgb = 0; m_src = 0; m_tag = 0; m_transp = 0; m_flash = 0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        if (!reset_n) begin
            model_reset();
            check("rst_valid", 32'(bus.out_valid), 0);
            check("rst_rgb", 32'({bus.out_red, bus.out_green, bus.out_blue}), 0);
            check("rst_src_tag", 32'({bus.out_src, bus.out_tag, bus.out_transparent}), 0);
            check("rst_ready", 32'(bus.req_ready), 0);
        end else begin
            int          g;
            logic        acc;
            logic [3:0]  idx;
            logic [11:0] col;
            check("out_valid", 32'(bus.out_valid), 32'(m_valid));
            check("out_rgb", 32'({bus.out_red, bus.out_green, bus.out_blue}), 32'(m_rgb));
            check("out_src", 32'(bus.out_src), 32'(m_src));
            check("out_tag", 32'(bus.out_tag), 32'(m_tag));
            check("out_transparent", 32'(bus.out_transparent), 32'(m_transp));
            acc = !m_valid || bus.out_ready;
            g = -1;
            if (acc) begin
                for (int k = 1; k <= N; k++) begin
                    if (g < 0 && bus.req_valid[(m_last + k) % N]) g = (m_last + k) % N;
                end
            end
            check("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
            if (g >= 0) begin
                idx = bus.req_index[g*4 +: 4];
                check("pal_index", 32'(bus.pal_index), 32'(idx));
                col = pal_rgb(idx);
                if (g == 0 && flash_en && m_flash >= 4 && idx != 4'd0) col = 12'hFFF;
                m_valid = 1; m_rgb = col; m_src = g; m_tag = bus.req_tag[g*10 +: 10];
                m_transp = (idx == 4'd0); m_last = g;
            end else begin
                if (bus.req_valid == '0) check("pal_index_idle", 32'(bus.pal_index), 0);
                if (acc) m_valid = 0;
            end
            if (!flash_en) m_flash = 0;
            else if (frame_start) m_flash = (m_flash + 1) % 8;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] idx, input logic [9:0] tag);
        bus.req_index[i*4 +: 4]  = idx;
        bus.req_tag[i*10 +: 10] = tag;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq [6] = '{0, 1, 2, 0, 1, 2};
        reset_n = 1'b0;
        flash_en = 1'b0;
        frame_start = 1'b0;
        bus.out_ready = 1'b1;
        bus.req_valid = 3'b111;
        set_req(0, 4'd3, 10'd100);
        set_req(1, 4'd1, 10'd101);
        set_req(2, 4'd2, 10'd102);
        repeat (3) tick();
        check("reset_ready", 32'(bus.req_ready), 0);

        reset_n = 1'b1;
        #1 check("first_ready", 32'(bus.req_ready), 32'b001);

        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_seq", 32'(bus.out_src), 32'(exp_seq[k]));
        end

        bus.out_ready = 1'b0;
        #1 check("stall_ready", 32'(bus.req_ready), 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stall_ready", 32'(bus.req_ready), 0);
            check("stall_src", 32'(bus.out_src), 2);
            check("stall_rgb", 32'({bus.out_red, bus.out_green, bus.out_blue}), 32'h456);
        end
        bus.out_ready = 1'b1;
        #1 check("unstall_ready", 32'(bus.req_ready), 32'b001);

        bus.req_valid = 3'b010;
        set_req(1, 4'd0, 10'd319);
        tick();
        check("transp_flag", 32'(bus.out_transparent), 1);
        check("transp_rgb", 32'({bus.out_red, bus.out_green, bus.out_blue}), 32'hF0C);
        check("transp_tag", 32'(bus.out_tag), 319);
        check("transp_src", 32'(bus.out_src), 1);

        for (int k = 0; k < 6; k++) begin
            bus.req_valid = (k % 2 == 0) ? 3'b100 : 3'b000;
            set_req(2, 4'(k + 5), 10'(k));
            tick();
            check("sparse_valid", 32'(bus.out_valid), (k % 2 == 0) ? 1 : 0);
            if (k % 2 == 0) check("sparse_src", 32'(bus.out_src), 2);
        end

`ifdef PAL_FLASH_EN
        flash_en = 1'b1;
        set_req(0, 4'd3, 10'd7);
        set_req(1, 4'd1, 10'd8);
        bus.req_valid = 3'b011;
        for (int f = 0; f < 8; f++) begin
            repeat (2) begin
                tick();
                if (bus.out_src == 0)
                    check("flash_src0", 32'({bus.out_red, bus.out_green, bus.out_blue}),
                          (f < 4) ? 32'h0AF : 32'hFFF);
                else
                    check("flash_src1", 32'({bus.out_red, bus.out_green, bus.out_blue}), 32'h123);
            end
            bus.req_valid = 3'b000;
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            bus.req_valid = 3'b011;
        end
        flash_en = 1'b0;
        repeat (2) tick();
`endif

        bus.out_ready = 1'b0;
        bus.req_valid = 3'b111;
        repeat (2) tick();
        check("pre_reset_valid", 32'(bus.out_valid), 1);
        reset_n = 1'b0;
        #1 check("midstall_reset_valid", 32'(bus.out_valid), 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("post_reset_src", 32'(bus.out_src), 0);
        bus.out_ready = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
